// File: rtl/renode_axi_burst_splitter.sv
// AXI4 burst splitter: turns any AR/AW burst into single-beat aligned INCR
// transactions toward the subordinate and reassembles one legal upstream burst.
module renode_axi_burst_splitter #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8
) (
  input  logic                          clk,
  input  logic                          areset_n,
  input  logic                          s_arvalid,
  input  logic [TransactionIdWidth-1:0] s_arid,
  input  logic [AddressWidth-1:0]       s_araddr,
  input  logic [7:0]                    s_arlen,
  input  logic [2:0]                    s_arsize,
  input  logic [1:0]                    s_arburst,
  output logic                          s_arready,
  output logic                          s_rvalid,
  output logic [TransactionIdWidth-1:0] s_rid,
  output logic [DataWidth-1:0]          s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  input  logic                          s_rready,
  input  logic                          s_awvalid,
  input  logic [TransactionIdWidth-1:0] s_awid,
  input  logic [AddressWidth-1:0]       s_awaddr,
  input  logic [7:0]                    s_awlen,
  input  logic [2:0]                    s_awsize,
  input  logic [1:0]                    s_awburst,
  output logic                          s_awready,
  input  logic                          s_wvalid,
  input  logic [DataWidth-1:0]          s_wdata,
  input  logic [DataWidth/8-1:0]        s_wstrb,
  input  logic                          s_wlast,
  output logic                          s_wready,
  output logic                          s_bvalid,
  output logic [TransactionIdWidth-1:0] s_bid,
  output logic [1:0]                    s_bresp,
  input  logic                          s_bready,
  output logic                          m_arvalid,
  output logic [TransactionIdWidth-1:0] m_arid,
  output logic [AddressWidth-1:0]       m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  input  logic                          m_arready,
  input  logic                          m_rvalid,
  input  logic [TransactionIdWidth-1:0] m_rid,
  input  logic [DataWidth-1:0]          m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  output logic                          m_rready,
  output logic                          m_awvalid,
  output logic [TransactionIdWidth-1:0] m_awid,
  output logic [AddressWidth-1:0]       m_awaddr,
  output logic [7:0]                    m_awlen,
  output logic [2:0]                    m_awsize,
  output logic [1:0]                    m_awburst,
  input  logic                          m_awready,
  output logic                          m_wvalid,
  output logic [DataWidth-1:0]          m_wdata,
  output logic [DataWidth/8-1:0]        m_wstrb,
  output logic                          m_wlast,
  input  logic                          m_wready,
  input  logic                          m_bvalid,
  input  logic [TransactionIdWidth-1:0] m_bid,
  input  logic [1:0]                    m_bresp,
  output logic                          m_bready
);
  localparam int AW = AddressWidth;
  localparam logic [2:0] MaxSize = 3'($clog2(DataWidth / 8));
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;
  typedef enum logic [2:0] {
    W_IDLE, W_ADDR, W_DATA, W_RESP, W_BRESP, W_ERR
  } w_state_t;

  function automatic logic [AW-1:0] align(
    input logic [AW-1:0] a, input logic [2:0] sz);
    return a & ~((AW'(1) << sz) - AW'(1));
  endfunction

  function automatic logic [AW-1:0] next_addr(
    input logic [AW-1:0] cur, input logic [2:0] sz,
    input logic [7:0] ln, input logic [1:0] bt);
    logic [AW-1:0] bytes, wmask;
    bytes = AW'(1) << sz;
    wmask = ((AW'(ln) + AW'(1)) << sz) - AW'(1);
    unique case (bt)
      2'b00:   return cur;
      2'b10:   return (cur & ~wmask) | ((cur + bytes) & wmask);
      default: return cur + bytes;
    endcase
  endfunction

  function automatic logic illegal(
    input logic [1:0] bt, input logic [7:0] ln, input logic [2:0] sz);
    logic wrap_ok;
    wrap_ok = ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15;
    return bt == 2'b11 || (bt == 2'b10 && !wrap_ok) || sz > MaxSize;
  endfunction

  // DECERR outranks SLVERR; OKAY and EXOKAY never displace anything.
  function automatic logic [1:0] worst(
    input logic [1:0] a, input logic [1:0] b);
    return (b[1] && (b > a || !a[1])) ? b : a;
  endfunction

  r_state_t r_state;
  w_state_t w_state;
  logic [7:0] r_len, r_cnt, w_len, w_cnt;
  logic [1:0] r_burst, w_burst, w_resp;
  logic r_last, w_last, unused_ok;

  assign r_last = r_cnt == r_len;
  assign w_last = w_cnt == w_len;
  assign unused_ok = ^{m_rid, m_rlast, m_bid};

  assign m_arlen   = 8'd0;
  assign m_arburst = 2'b01;
  assign m_awlen   = 8'd0;
  assign m_awburst = 2'b01;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arsize  <= '0;
      r_len     <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          s_arready <= 1'b1;
          if (s_arready && s_arvalid) begin
            s_arready <= 1'b0;
            m_arid    <= s_arid;
            m_arsize  <= s_arsize;
            r_len     <= s_arlen;
            r_burst   <= s_arburst;
            r_cnt     <= '0;
            m_araddr  <= align(s_araddr, s_arsize);
            if (illegal(s_arburst, s_arlen, s_arsize)) begin
              r_state <= R_ERR;
            end else begin
              m_arvalid <= 1'b1;
              r_state   <= R_ADDR;
            end
          end
        end
        R_ADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          r_state   <= R_DATA;
        end
        R_DATA: if (m_rvalid && s_rready) begin
          if (r_last) begin
            r_state <= R_IDLE;
          end else begin
            r_cnt     <= r_cnt + 8'd1;
            m_araddr  <= next_addr(m_araddr, m_arsize, r_len, r_burst);
            m_arvalid <= 1'b1;
            r_state   <= R_ADDR;
          end
        end
        R_ERR: if (s_rready) begin
          if (r_last) r_state <= R_IDLE;
          else r_cnt <= r_cnt + 8'd1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_rvalid = (r_state == R_DATA) ? m_rvalid : (r_state == R_ERR);
  assign m_rready = (r_state == R_DATA) && s_rready;
  assign s_rdata  = (r_state == R_DATA) ? m_rdata : '0;
  assign s_rresp  = (r_state == R_DATA) ? m_rresp
                  : (r_state == R_ERR) ? SLVERR : 2'b00;
  assign s_rlast  = (r_state == R_DATA || r_state == R_ERR) && r_last;
  assign s_rid    = (r_state == R_DATA || r_state == R_ERR) ? m_arid : '0;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b0;
      m_awvalid <= 1'b0;
      m_awid    <= '0;
      m_awaddr  <= '0;
      m_awsize  <= '0;
      w_len     <= '0;
      w_burst   <= '0;
      w_cnt     <= '0;
      w_resp    <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          s_awready <= 1'b1;
          if (s_awready && s_awvalid) begin
            s_awready <= 1'b0;
            m_awid    <= s_awid;
            m_awsize  <= s_awsize;
            w_len     <= s_awlen;
            w_burst   <= s_awburst;
            w_cnt     <= '0;
            w_resp    <= 2'b00;
            m_awaddr  <= align(s_awaddr, s_awsize);
            if (illegal(s_awburst, s_awlen, s_awsize)) begin
              w_state <= W_ERR;
            end else begin
              m_awvalid <= 1'b1;
              w_state   <= W_ADDR;
            end
          end
        end
        W_ADDR: if (m_awready) begin
          m_awvalid <= 1'b0;
          w_state   <= W_DATA;
        end
        W_DATA: if (s_wvalid && m_wready) begin
          if (s_wlast != w_last) w_resp <= worst(w_resp, SLVERR);
          w_state <= W_RESP;
        end
        W_RESP: if (m_bvalid) begin
          w_resp <= worst(w_resp, m_bresp);
          if (w_last) begin
            w_state <= W_BRESP;
          end else begin
            w_cnt     <= w_cnt + 8'd1;
            m_awaddr  <= next_addr(m_awaddr, m_awsize, w_len, w_burst);
            m_awvalid <= 1'b1;
            w_state   <= W_ADDR;
          end
        end
        W_BRESP: if (s_bready) w_state <= W_IDLE;
        W_ERR: if (s_wvalid) begin
          if (w_last) begin
            w_resp  <= SLVERR;
            w_state <= W_BRESP;
          end else begin
            w_cnt <= w_cnt + 8'd1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign m_wvalid = (w_state == W_DATA) && s_wvalid;
  assign s_wready = (w_state == W_DATA) ? m_wready : (w_state == W_ERR);
  assign m_wdata  = (w_state == W_DATA) ? s_wdata : '0;
  assign m_wstrb  = (w_state == W_DATA) ? s_wstrb : '0;
  assign m_wlast  = (w_state == W_DATA);
  assign m_bready = (w_state == W_RESP);
  assign s_bvalid = (w_state == W_BRESP);
  assign s_bid    = (w_state == W_BRESP) ? m_awid : '0;
  assign s_bresp  = (w_state == W_BRESP) ? w_resp : 2'b00;

endmodule

// File: tb/tb_renode_axi_burst_splitter.sv
// Directed bench for renode_axi_burst_splitter: a simple downstream
// subordinate model plus upstream read/write tasks with fixed expectations.
module tb_renode_axi_burst_splitter;
  logic        clk, areset_n;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [7:0]  s_arid, s_rid, s_arlen;
  logic [31:0] s_araddr, s_rdata;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
  logic [7:0]  s_awid, s_awlen, s_bid;
  logic [31:0] s_awaddr, s_wdata;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst, s_bresp;
  logic [3:0]  s_wstrb, m_wstrb;
  logic        s_bvalid, s_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [7:0]  m_arid, m_rid, m_arlen;
  logic [31:0] m_araddr, m_rdata;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
  logic [7:0]  m_awid, m_awlen, m_bid;
  logic [31:0] m_awaddr, m_wdata;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp;
  logic        m_bvalid, m_bready;

  int checks = 0;
  int failures = 0;
  int ar_seen = 0;
  int aw_seen = 0;
  logic [31:0] ar_q[$], aw_q[$], wl_q[$];
  logic [31:0] rd_q[$], rr_q[$], rl_q[$], ri_q[$];
  logic [31:0] bresp_q[$], bid_q[$], bscript[$], eq[$];

  renode_axi_burst_splitter dut (
    .clk(clk), .areset_n(areset_n),
    .s_arvalid(s_arvalid), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_bready(s_bready),
    .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp),
    .m_bready(m_bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cmp_list(input string tag, input logic [31:0] got[$],
                          input logic [31:0] exp[$]);
    chk({tag, "_n"}, got.size(), exp.size());
    foreach (exp[i])
      if (i < got.size()) chk($sformatf("%s%0d", tag, i), got[i], exp[i]);
  endtask

  // Downstream subordinate: zero-wait AR/AW/W, R data = ~addr, scripted B.
  initial begin
    forever begin
      logic ar_hs, r_hs, w_hs, b_hs;
      logic [31:0] a_s;
      logic [7:0] id_s;
      @(negedge clk);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      w_hs  = m_wvalid && m_wready;
      b_hs  = m_bvalid && m_bready;
      a_s   = m_araddr;
      id_s  = m_arid;
      if (m_arvalid) ar_seen++;
      if (m_awvalid) aw_seen++;
      if (ar_hs) ar_q.push_back(m_araddr);
      if (m_awvalid && m_awready) aw_q.push_back(m_awaddr);
      if (w_hs) wl_q.push_back({31'd0, m_wlast});
      if (s_rvalid && s_rready) begin
        rd_q.push_back(s_rdata);
        rr_q.push_back({30'd0, s_rresp});
        rl_q.push_back({31'd0, s_rlast});
        ri_q.push_back({24'd0, s_rid});
      end
      if (s_bvalid && s_bready) begin
        bresp_q.push_back({30'd0, s_bresp});
        bid_q.push_back({24'd0, s_bid});
      end
      @(posedge clk);
      #1;
      if (r_hs) m_rvalid = 1'b0;
      if (ar_hs) begin
        m_rvalid = 1'b1;
        m_rdata  = ~a_s;
        m_rid    = id_s;
        m_rresp  = 2'b00;
        m_rlast  = 1'b1;
      end
      if (b_hs) m_bvalid = 1'b0;
      if (w_hs) begin
        m_bvalid = 1'b1;
        m_bresp  = (bscript.size() > 0) ? bscript.pop_front() : 2'b00;
      end
    end
  end

  task automatic clear_q();
    ar_q.delete(); aw_q.delete(); wl_q.delete();
    rd_q.delete(); rr_q.delete(); rl_q.delete(); ri_q.delete();
    bresp_q.delete(); bid_q.delete();
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] a,
                         input logic [7:0] ln, input logic [2:0] sz,
                         input logic [1:0] bt);
    int n = 0;
    @(posedge clk);
    #1;
    s_arid = id; s_araddr = a; s_arlen = ln;
    s_arsize = sz; s_arburst = bt; s_arvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_arready && n < 50);
    chk("ar_timeout", {31'd0, n < 50}, 1);
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] a,
                         input logic [7:0] ln, input logic [2:0] sz,
                         input logic [1:0] bt);
    int n = 0;
    clear_q();
    send_ar(id, a, ln, sz, bt);
    while (rd_q.size() < int'(ln) + 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("r_timeout", {31'd0, n < 500}, 1);
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] a,
                          input logic [7:0] ln, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [15:0] lm);
    int n = 0;
    clear_q();
    @(posedge clk);
    #1;
    s_awid = id; s_awaddr = a; s_awlen = ln;
    s_awsize = sz; s_awburst = bt; s_awvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_awready && n < 50);
    chk("aw_timeout", {31'd0, n < 50}, 1);
    for (int i = 0; i <= int'(ln); i++) begin
      @(posedge clk);
      #1;
      s_awvalid = 1'b0;
      s_wvalid = 1'b1;
      s_wdata = 32'hD000 + i;
      s_wstrb = 4'hF;
      s_wlast = lm[i];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_wready && n < 50);
      chk("w_timeout", {31'd0, n < 50}, 1);
    end
    @(posedge clk);
    #1;
    s_wvalid = 1'b0;
    s_wlast = 1'b0;
    n = 0;
    while (bresp_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_timeout", {31'd0, n < 200}, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int s, n;
    areset_n = 1'b0;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0;
    s_arsize = 0; s_arburst = 0; s_rready = 1'b1;
    s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0;
    s_awsize = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 1'b1;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    m_rvalid = 0; m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
    m_bvalid = 0; m_bid = 0; m_bresp = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", {31'd0, s_arready}, 0);
    chk("rst_awready", {31'd0, s_awready}, 0);
    chk("rst_arvalid", {31'd0, m_arvalid}, 0);
    chk("rst_awvalid", {31'd0, m_awvalid}, 0);
    chk("rst_rvalid", {31'd0, s_rvalid}, 0);
    chk("rst_bvalid", {31'd0, s_bvalid}, 0);
    chk("rst_araddr", m_araddr, 0);
    @(negedge clk);
    areset_n = 1'b1;
    #1;
    chk("rel_arready", {31'd0, s_arready}, 0);
    @(posedge clk);
    #1;
    chk("post_arready", {31'd0, s_arready}, 1);
    chk("post_awready", {31'd0, s_awready}, 1);

    do_read(8'h05, 32'h100, 8'd3, 3'd2, 2'b01);
    eq = '{32'h100, 32'h104, 32'h108, 32'h10C};
    cmp_list("t1_addr", ar_q, eq);
    eq = '{0, 0, 0, 1};
    cmp_list("t1_last", rl_q, eq);
    eq = '{32'hFFFFFEFF, 32'hFFFFFEFB, 32'hFFFFFEF7, 32'hFFFFFEF3};
    cmp_list("t1_data", rd_q, eq);
    eq = '{5, 5, 5, 5};
    cmp_list("t1_id", ri_q, eq);

    do_read(8'h01, 32'h10C, 8'd3, 3'd2, 2'b10);
    eq = '{32'h10C, 32'h100, 32'h104, 32'h108};
    cmp_list("t2_wrap", ar_q, eq);
    do_read(8'h02, 32'h20, 8'd2, 3'd2, 2'b00);
    eq = '{32'h20, 32'h20, 32'h20};
    cmp_list("t2_fixed", ar_q, eq);
    eq = '{0, 0, 1};
    cmp_list("t2_last", rl_q, eq);

    bscript = '{32'd0, 32'd2};
    do_write(8'h3C, 32'h0, 8'd1, 3'd2, 2'b01, 16'b10);
    eq = '{32'h0, 32'h4};
    cmp_list("t3_aw", aw_q, eq);
    eq = '{1, 1};
    cmp_list("t3_wlast", wl_q, eq);
    eq = '{2};
    cmp_list("t3_bresp", bresp_q, eq);
    eq = '{32'h3C};
    cmp_list("t3_bid", bid_q, eq);

    bscript = '{32'd0, 32'd0};
    do_write(8'h07, 32'h40, 8'd1, 3'd2, 2'b01, 16'b01);
    eq = '{2};
    cmp_list("t3_badlast", bresp_q, eq);
    bscript = '{32'd1, 32'd3, 32'd2};
    do_write(8'h09, 32'h80, 8'd2, 3'd2, 2'b01, 16'b100);
    eq = '{3};
    cmp_list("t3_decerr", bresp_q, eq);
    bscript = '{32'd1, 32'd0};
    do_write(8'h0A, 32'h90, 8'd1, 3'd2, 2'b01, 16'b10);
    eq = '{0};
    cmp_list("t3_okay", bresp_q, eq);

    do_read(8'h03, 32'h103, 8'd0, 3'd2, 2'b01);
    eq = '{32'h100};
    cmp_list("t4_align", ar_q, eq);
    eq = '{1};
    cmp_list("t4_alast", rl_q, eq);

    s = ar_seen;
    do_read(8'h04, 32'h200, 8'd1, 3'd2, 2'b11);
    chk("t4_noar", ar_seen - s, 0);
    eq = '{2, 2};
    cmp_list("t4_resp", rr_q, eq);
    eq = '{0, 1};
    cmp_list("t4_last", rl_q, eq);
    eq = '{0, 0};
    cmp_list("t4_data", rd_q, eq);
    eq = '{4, 4};
    cmp_list("t4_id", ri_q, eq);
    do_read(8'h0B, 32'h0, 8'd2, 3'd2, 2'b10);
    eq = '{2, 2, 2};
    cmp_list("t4_wraplen", rr_q, eq);
    do_read(8'h0C, 32'h0, 8'd0, 3'd3, 2'b01);
    eq = '{2};
    cmp_list("t4_size", rr_q, eq);
    chk("t4_noar2", ar_seen - s, 0);

    s = aw_seen;
    do_write(8'h11, 32'h0, 8'd1, 3'd2, 2'b11, 16'b10);
    chk("t4_noaw", aw_seen - s, 0);
    chk("t4_now", wl_q.size(), 0);
    eq = '{2};
    cmp_list("t4_wresp", bresp_q, eq);
    eq = '{32'h11};
    cmp_list("t4_wid", bid_q, eq);

    do_read(8'h06, 32'hFFFFFFFC, 8'd1, 3'd2, 2'b01);
    eq = '{32'hFFFFFFFC, 32'h0};
    cmp_list("t5_wrap", ar_q, eq);

    clear_q();
    s_rready = 1'b0;
    send_ar(8'h08, 32'h200, 8'd3, 3'd2, 2'b01);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_rvalid && n < 50);
    #1;
    s_rready = 1'b1;
    @(posedge clk);
    #1;
    s_rready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_rvalid && n < 50);
    chk("t6_beat2", {31'd0, s_rvalid}, 1);
    #2;
    areset_n = 1'b0;
    #1;
    chk("t6_rvalid", {31'd0, s_rvalid}, 0);
    chk("t6_arvalid", {31'd0, m_arvalid}, 0);
    chk("t6_rready", {31'd0, m_rready}, 0);
    chk("t6_arready", {31'd0, s_arready}, 0);
    chk("t6_rid", {24'd0, s_rid}, 0);
    m_rvalid = 1'b0;
    s_rready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset_n = 1'b1;
    do_read(8'h09, 32'h300, 8'd1, 3'd2, 2'b01);
    eq = '{32'h300, 32'h304};
    cmp_list("t6_addr", ar_q, eq);
    eq = '{0, 1};
    cmp_list("t6_last", rl_q, eq);
    eq = '{32'hFFFFFCFF, 32'hFFFFFCFB};
    cmp_list("t6_data", rd_q, eq);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
